// File: rtl/fse_lms_eq.sv
// T/2 fractionally spaced FIR equalizer with sign-decision LMS adaptation for one rail (I or Q).
// Optional feature macro: FSE_LMS_EN enables the coefficient update path, P_UPD and i_freeze.
module fse_lms_eq #(
    parameter int                          NTAPS    = 7,
    parameter int                          NBT_IN   = 8,
    parameter int                          NBF_IN   = 7,
    parameter int                          NBT_COEF = 12,
    parameter int                          NBF_COEF = 10,
    parameter int                          NBT_OUT  = 9,
    parameter int                          NBF_OUT  = 7,
    parameter logic signed [NBT_OUT-1:0]   TARGET   = 9'sh040,
    parameter int                          MU_SHIFT = 6
) (
    input  logic                        clk,
    input  logic                        i_reset,
    input  logic signed [NBT_IN-1:0]    i_is_data,
    input  logic                        i_en_sample,
    input  logic                        i_en_symbol,
    input  logic                        i_freeze,
    output logic signed [NBT_OUT-1:0]   o_os_data,
    output logic                        o_sym,
    output logic signed [NBT_OUT:0]     o_err,
    output logic                        o_valid
);

    localparam int CNT_W  = (NTAPS > 2) ? $clog2(NTAPS) : 1;
    localparam int ACC_W  = NBT_IN + NBT_COEF + $clog2(NTAPS);
    localparam int SH_OUT = NBF_IN + NBF_COEF - NBF_OUT;
    localparam int CTR    = NTAPS / 2;

    localparam logic signed [NBT_COEF-1:0] C_ONE = NBT_COEF'(1 << NBF_COEF);
    localparam logic signed [ACC_W-1:0]    Y_HI  = ACC_W'((1 << (NBT_OUT - 1)) - 1);
    localparam logic signed [ACC_W-1:0]    Y_LO  = ~Y_HI;
    localparam logic signed [NBT_OUT:0]    T_POS = {TARGET[NBT_OUT-1], TARGET};
    localparam logic signed [NBT_OUT:0]    T_NEG = -T_POS;

    typedef enum logic       {FILL, RUN} top_state_t;
    typedef enum logic [1:0] {P_IDLE, P_FILT, P_UPD} pipe_state_t;

    top_state_t                 top_q, top_d;
    pipe_state_t                pipe_q, pipe_d;
    logic [CNT_W-1:0]           fill_cnt_q, fill_cnt_d;
    logic signed [NBT_IN-1:0]   line_q [NTAPS];
    logic signed [NBT_IN-1:0]   line_d [NTAPS];
    logic signed [NBT_COEF-1:0] coef [NTAPS];

    logic signed [NBT_OUT-1:0]  os_data_q, os_data_d;
    logic                       sym_q, sym_d;
    logic signed [NBT_OUT:0]    err_q, err_d;
    logic                       valid_q, valid_d;

    logic signed [ACC_W-1:0]    line_ext [NTAPS];
    logic signed [ACC_W-1:0]    coef_ext [NTAPS];
    logic signed [ACC_W-1:0]    prod [NTAPS];
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    y_full;
    logic signed [NBT_OUT-1:0]  y_sat;
    logic signed [NBT_OUT:0]    y_ext;
    logic signed [NBT_OUT:0]    d_val;
    logic signed [NBT_OUT:0]    err_val;

    // Full-precision products; the accumulator width cannot overflow for NTAPS terms.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_mac
            assign line_ext[gi] = {{(ACC_W-NBT_IN){line_q[gi][NBT_IN-1]}}, line_q[gi]};
            assign coef_ext[gi] = {{(ACC_W-NBT_COEF){coef[gi][NBT_COEF-1]}}, coef[gi]};
            assign prod[gi]     = line_ext[gi] * coef_ext[gi];
        end
    endgenerate

    always_comb begin
        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + prod[k];
        end
        y_full = acc >>> SH_OUT;
        if (y_full > Y_HI) begin
            y_sat = {1'b0, {(NBT_OUT-1){1'b1}}};
        end else if (y_full < Y_LO) begin
            y_sat = {1'b1, {(NBT_OUT-1){1'b0}}};
        end else begin
            y_sat = y_full[NBT_OUT-1:0];
        end
        y_ext   = {y_sat[NBT_OUT-1], y_sat};
        d_val   = y_sat[NBT_OUT-1] ? T_NEG : T_POS;
        err_val = d_val - y_ext;
    end

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            line_d[k] = line_q[k];
        end
        if (i_en_sample) begin
            line_d[0] = i_is_data;
            for (int k = 1; k < NTAPS; k++) begin
                line_d[k] = line_q[k-1];
            end
        end
    end

    always_comb begin
        top_d      = top_q;
        fill_cnt_d = fill_cnt_q;
        pipe_d     = pipe_q;
        os_data_d  = os_data_q;
        sym_d      = sym_q;
        err_d      = err_q;
        valid_d    = 1'b0;

        if (top_q == FILL && i_en_sample) begin
            if (fill_cnt_q == CNT_W'(NTAPS - 1)) begin
                top_d = RUN;
            end else begin
                fill_cnt_d = fill_cnt_q + CNT_W'(1);
            end
        end

        case (pipe_q)
            P_IDLE: begin
                if (top_q == RUN && i_en_symbol && i_en_sample) begin
                    pipe_d = P_FILT;
                end
            end
            P_FILT: begin
`ifdef FSE_LMS_EN
                pipe_d = P_UPD;
`else
                pipe_d = P_IDLE;
`endif
                os_data_d = y_sat;
                sym_d     = ~y_sat[NBT_OUT-1];
                err_d     = err_val;
                valid_d   = 1'b1;
            end
            default: pipe_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            top_q      <= FILL;
            pipe_q     <= P_IDLE;
            fill_cnt_q <= '0;
            os_data_q  <= '0;
            sym_q      <= 1'b0;
            err_q      <= '0;
            valid_q    <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                line_q[k] <= '0;
            end
        end else begin
            top_q      <= top_d;
            pipe_q     <= pipe_d;
            fill_cnt_q <= fill_cnt_d;
            os_data_q  <= os_data_d;
            sym_q      <= sym_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            for (int k = 0; k < NTAPS; k++) begin
                line_q[k] <= line_d[k];
            end
        end
    end

`ifdef FSE_LMS_EN
    localparam int PROD_W = NBT_OUT + 1 + NBT_IN;
    localparam int SH_UPD = NBF_OUT + NBF_IN - NBF_COEF + MU_SHIFT;
    localparam int SUM_W  = ((PROD_W > NBT_COEF) ? PROD_W : NBT_COEF) + 1;
    localparam logic signed [SUM_W-1:0] C_HI = SUM_W'((1 << (NBT_COEF - 1)) - 1);
    localparam logic signed [SUM_W-1:0] C_LO = ~C_HI;

    logic signed [NBT_IN-1:0]   reg_q [NTAPS];
    logic signed [NBT_IN-1:0]   reg_d [NTAPS];
    logic signed [NBT_COEF-1:0] coef_q [NTAPS];
    logic signed [NBT_COEF-1:0] coef_d [NTAPS];
    logic signed [PROD_W-1:0]   upd_prod [NTAPS];
    logic signed [PROD_W-1:0]   upd_step [NTAPS];
    logic signed [SUM_W-1:0]    upd_sum [NTAPS];
    logic signed [NBT_COEF-1:0] coef_new [NTAPS];

    // The regressor is a snapshot taken leaving P_FILT, so a sample shift at E2 cannot disturb it.
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_upd
            assign upd_prod[gi] = $signed({{(PROD_W-NBT_OUT-1){err_q[NBT_OUT]}}, err_q})
                                * $signed({{(PROD_W-NBT_IN){reg_q[gi][NBT_IN-1]}}, reg_q[gi]});
            assign upd_step[gi] = upd_prod[gi] >>> SH_UPD;
            assign upd_sum[gi]  = {{(SUM_W-PROD_W){upd_step[gi][PROD_W-1]}}, upd_step[gi]}
                                + {{(SUM_W-NBT_COEF){coef_q[gi][NBT_COEF-1]}}, coef_q[gi]};
            assign coef_new[gi] = (upd_sum[gi] > C_HI) ? {1'b0, {(NBT_COEF-1){1'b1}}} :
                                  (upd_sum[gi] < C_LO) ? {1'b1, {(NBT_COEF-1){1'b0}}} :
                                  upd_sum[gi][NBT_COEF-1:0];
            assign coef[gi]     = coef_q[gi];
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            reg_d[k]  = reg_q[k];
            coef_d[k] = coef_q[k];
            if (pipe_q == P_FILT) begin
                reg_d[k] = line_q[k];
            end
            if (pipe_q == P_UPD && !i_freeze) begin
                coef_d[k] = coef_new[k];
            end
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                reg_q[k]  <= '0;
                coef_q[k] <= (k == CTR) ? C_ONE : '0;
            end
        end else begin
            for (int k = 0; k < NTAPS; k++) begin
                reg_q[k]  <= reg_d[k];
                coef_q[k] <= coef_d[k];
            end
        end
    end
`else
    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_const
            assign coef[gi] = (gi == CTR) ? C_ONE : '0;
        end
    endgenerate

    logic unused_freeze;
    assign unused_freeze = i_freeze;
`endif

    assign o_os_data = os_data_q;
    assign o_sym     = sym_q;
    assign o_err     = err_q;
    assign o_valid   = valid_q;

endmodule

// File: tb/tb_fse_lms_eq.sv
// Scoreboard bench for fse_lms_eq: two instances (TARGET 0.5 and TARGET 0x0FF) share one stimulus
// stream; an arithmetic reference model predicts every output group.
module tb_fse_lms_eq;
    localparam int NTAPS = 7;
    localparam int NI    = 2;
    localparam int SH_Y  = 7 + 10 - 7;
    localparam int SH_U  = 7 + 7 - 10 + 6;
`ifdef FSE_LMS_EN
    localparam bit LMS = 1'b1;
`else
    localparam bit LMS = 1'b0;
`endif

    typedef struct {
        int edge_n;
        int y0;
        int e0;
        int y1;
        int e1;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic signed [7:0] data;
    logic              samp;
    logic              sym;
    logic              frz;
    logic signed [8:0] os_data [NI];
    logic              osym    [NI];
    logic signed [9:0] oerr    [NI];
    logic              ovalid  [NI];

    int   edges = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   done = 1'b0;
    exp_t exp_q[$];

    // reference model state
    int hist [NTAPS];
    int coef [NI][NTAPS];
    int regr [NTAPS];
    int pend_err [NI];
    int pend_edge;
    int fill_cnt;
    bit run;
    int last_acc;

    fse_lms_eq u_dut (
        .clk(clk), .i_reset(rst_n), .i_is_data(data), .i_en_sample(samp),
        .i_en_symbol(sym), .i_freeze(frz), .o_os_data(os_data[0]), .o_sym(osym[0]),
        .o_err(oerr[0]), .o_valid(ovalid[0])
    );

    fse_lms_eq #(.TARGET(9'sh0FF)) u_dut_sat (
        .clk(clk), .i_reset(rst_n), .i_is_data(data), .i_en_sample(samp),
        .i_en_symbol(sym), .i_freeze(frz), .o_os_data(os_data[1]), .o_sym(osym[1]),
        .o_err(oerr[1]), .o_valid(ovalid[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    function automatic int target_of(input int inst);
        return (inst == 0) ? 64 : 255;
    endfunction

    task automatic model_reset();
        fill_cnt  = 0;
        run       = 1'b0;
        pend_edge = -1;
        last_acc  = -100;
        for (int k = 0; k < NTAPS; k++) begin
            hist[k] = 0;
            for (int i = 0; i < NI; i++) coef[i][k] = (k == NTAPS / 2) ? 1024 : 0;
        end
    endtask

    // Predicts the effect of clock edge number e with the inputs currently driven.
    task automatic model_edge(input int e);
        exp_t x;
        int   acc, y, d, err;
        int   ys [NI];
        int   es [NI];
        bit   accept;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (LMS && pend_edge == e) begin
            if (!frz) begin
                for (int i = 0; i < NI; i++)
                    for (int k = 0; k < NTAPS; k++)
                        coef[i][k] = clampi(coef[i][k] + ((pend_err[i] * regr[k]) >>> SH_U), -2048, 2047);
            end
            pend_edge = -1;
        end
        accept = run && samp && sym && ((e - last_acc) >= (LMS ? 3 : 2));
        if (samp) begin
            for (int k = NTAPS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'(data);
            if (!run) begin
                fill_cnt++;
                if (fill_cnt == NTAPS) run = 1'b1;
            end
        end
        if (accept) begin
            last_acc = e;
            for (int i = 0; i < NI; i++) begin
                acc = 0;
                for (int k = 0; k < NTAPS; k++) acc += coef[i][k] * hist[k];
                y   = clampi(acc >>> SH_Y, -256, 255);
                d   = (y >= 0) ? target_of(i) : -target_of(i);
                err = d - y;
                ys[i] = y;
                es[i] = err;
                pend_err[i] = err;
            end
            for (int k = 0; k < NTAPS; k++) regr[k] = hist[k];
            pend_edge = e + 2;
            x.edge_n = e + 1;
            x.y0 = ys[0];
            x.e0 = es[0];
            x.y1 = ys[1];
            x.e1 = es[1];
            exp_q.push_back(x);
        end
    endtask

    task automatic cyc(input bit r, input logic signed [7:0] d, input bit s, input bit y, input bit f);
        @(posedge clk);
        #1;
        if (!r) exp_q.delete();
        rst_n = r;
        data  = d;
        samp  = s;
        sym   = y;
        frz   = f;
        model_edge(edges + 1);
    endtask

    task automatic stream(input int nsym, input int gap, input bit fr, input logic signed [7:0] cval);
        for (int s = 0; s < 2 * nsym; s++) begin
            cyc(1'b1, cval, 1'b1, s[0], fr);
            for (int g = 1; g < gap; g++) cyc(1'b1, cval, 1'b0, 1'b0, fr);
        end
    endtask

    task automatic random_phase(input int ncyc);
        int since;
        bit s;
        since = 9;
        for (int c = 0; c < ncyc; c++) begin
            s = (since >= 2) && ($urandom_range(0, 1) == 1);
            since = s ? 1 : since + 1;
            cyc(1'b1, 8'($urandom), s, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic anomalies();
        cyc(1'b1, 8'sh11, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, 8'($urandom), 1'b0, 1'b1, 1'b0);
            cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        end
        cyc(1'b1, 8'sh25, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'sh25, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, -8'sh31, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) cyc(1'b1, 8'sh00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid_reset();
        for (int c = 0; c < 3; c++) cyc(1'b1, 8'sh30, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 8'sh30, 1'b1, 1'b1, 1'b0);
        cyc(1'b1, 8'sh30, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'sh30, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 8'sh30, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic chk(input string name, input int inst, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0d, expected %0d (edge %0d)", name, inst, act, expv, edges);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                chk("reset_os_data", i, int'(os_data[i]), 0);
                chk("reset_sym", i, int'(osym[i]), 0);
                chk("reset_err", i, int'(oerr[i]), 0);
                chk("reset_valid", i, int'(ovalid[i]), 0);
            end
        end else if (ovalid[0] || ovalid[1]) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid0", 0, int'(ovalid[0]), 0);
                chk("unexpected_valid1", 1, int'(ovalid[1]), 0);
            end else begin
                x = exp_q.pop_front();
                chk("valid_edge", 0, edges, x.edge_n);
                chk("valid", 0, int'(ovalid[0]), 1);
                chk("valid", 1, int'(ovalid[1]), 1);
                chk("os_data", 0, int'(os_data[0]), x.y0);
                chk("sym", 0, int'(osym[0]), (x.y0 >= 0) ? 1 : 0);
                chk("err", 0, int'(oerr[0]), x.e0);
                chk("os_data", 1, int'(os_data[1]), x.y1);
                chk("sym", 1, int'(osym[1]), (x.y1 >= 0) ? 1 : 0);
                chk("err", 1, int'(oerr[1]), x.e1);
                $display("[TB] edge %0d y0=%0d e0=%0d y1=%0d e1=%0d", edges,
                         int'(os_data[0]), int'(oerr[0]), int'(os_data[1]), int'(oerr[1]));
            end
        end else if (exp_q.size() > 0 && exp_q[0].edge_n <= edges) begin
            x = exp_q.pop_front();
            chk("missing_valid", 0, 0, 1);
        end
        if (done) begin
            chk("queue_empty", 0, exp_q.size(), 0);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        rst_n = 1'b0;
        data  = '0;
        samp  = 1'b0;
        sym   = 1'b0;
        frz   = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) cyc(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        stream(20, 2, 1'b1, 8'sh40);
        stream(10, 4, 1'b1, 8'sh40);
        stream(2000, 2, 1'b0, 8'sh20);
        stream(300, 2, 1'b0, 8'sh7F);
        random_phase(3000);
        anomalies();
        mid_reset();
        stream(12, 2, 1'b1, 8'sh40);
        for (int c = 0; c < 6; c++) cyc(1'b1, 8'sh00, 1'b0, 1'b0, 1'b0);
        done = 1'b1;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule
